uart_tx_arbiter: RTL

//  Shares the single uart_tx transmitter between NUM_REQ byte-stream clients (LED status, debug, etc.).

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_arb_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
// Optional ID-tag byte per packet is enabled by defining UART_ARB_TAG_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_SEND = 2'd2
    } arb_state_e;

    localparam logic [7:0] TAG_BASE_DEF = 8'h30;
    localparam int         NUM_REQ_MIN  = 2;
    localparam int         NUM_REQ_MAX  = 8;

    function automatic logic [7:0] tag_byte(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [$clog2(N)-1:0]  ptr_i,
    output logic [N-1:0]          onehot_o,
    output logic [$clog2(N)-1:0]  idx_o,
    output logic                  any_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                idx_o           = cand;
                onehot_o[cand]  = 1'b1;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte-stream clients, round-robin per atomic packet.
// Define UART_ARB_TAG_EN to prefix each packet with an ID byte TAG_BASE + client index.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ     = 4,
    parameter int         MAX_PKT_LEN = 64,
    parameter logic [7:0] TAG_BASE    = TAG_BASE_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);

`ifdef UART_ARB_TAG_EN
    localparam arb_state_e GRANT_STATE = ST_TAG;
`else
    localparam arb_state_e GRANT_STATE = ST_SEND;
`endif

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ out of supported range");
    end

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       gidx_q,  gidx_d;
    logic [IW-1:0]       ptr_q,   ptr_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic                start_q, start_d;
    logic [7:0]          data_q,  data_d;
    logic [NUM_REQ-1:0]  ack_q,   ack_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                issue_tag;
    logic                issue_pay;
    logic [7:0]          pay_byte [NUM_REQ];

    uart_arb_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pay_byte[i] = req_data_i[8*i +: 8];
        end
    end

    // The !start_q term keeps tx_start a single-cycle pulse with a gap, giving
    // uart_tx one cycle to drop tx_ready after accepting a byte.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        data_d    = data_q;
        ack_d     = '0;
        issue_tag = 1'b0;
        issue_pay = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    state_d = GRANT_STATE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                if (tx_ready_i && !start_q) begin
                    issue_tag = 1'b1;
                    state_d   = ST_SEND;
                end
            end
`endif
            ST_SEND: begin
                if (req_i[gidx_q] && tx_ready_i && !start_q) begin
                    issue_pay     = 1'b1;
                    ack_d[gidx_q] = 1'b1;
                    cnt_d         = cnt_q + 1'b1;
                    // Forced release at MAX_PKT_LEN stops one client hogging the line.
                    if (req_last_i[gidx_q] || cnt_q == CW'(MAX_PKT_LEN - 1)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (issue_tag || issue_pay) begin
            start_d = 1'b1;
            data_d  = issue_tag ? tag_byte(TAG_BASE, 8'(gidx_q)) : pay_byte[gidx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign grant_o    = grant_q;
    assign req_ack_o  = ack_q;
    assign tx_start_o = start_q;
    assign tx_data_o  = data_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
